// File: rtl/tile_palette_pkg.sv
// Shared colour type and the power-on palette contents for tile_palette.
// The blink timer lives in rtl/tile_palette_blink_timer.sv.
package tile_palette_pkg;

  localparam int COLOR_BITS = 24;

  typedef logic [COLOR_BITS-1:0] color_t;

  localparam color_t DEFAULT_COLOR = 24'hDCDCDC;

  // Entries beyond the explicit table fall back to DEFAULT_COLOR.
  function automatic color_t default_color(input int unsigned idx);
    color_t c;
    case (idx)
      0:       c = 24'hFFFF99;
      1:       c = 24'hFFFFCC;
      2:       c = 24'hFFFFE6;
      3:       c = 24'hFFCC99;
      4:       c = 24'hFFCCCC;
      5:       c = 24'hFFCC99;
      6:       c = 24'hFF9999;
      7:       c = 24'hFFCCCC;
      8:       c = 24'hFF99CC;
      9:       c = 24'hCC6666;
      10:      c = 24'h993333;
      11:      c = 24'hCCFFCC;
      default: c = DEFAULT_COLOR;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/tile_palette_blink_timer.sv
// Blink half-period timer for tile_palette: counts while enabled and
// flips phase each time the count wraps.
module blink_timer #(
  parameter int BLINK_PERIOD = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic phase
);

  localparam int CNT_W = $clog2(BLINK_PERIOD);

  logic [CNT_W-1:0] count_reg;
  logic             phase_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
      phase_reg <= 1'b0;
    end else if (!en) begin
      count_reg <= '0;
      phase_reg <= 1'b0;
    end else if (count_reg == CNT_W'(BLINK_PERIOD - 1)) begin
      count_reg <= '0;
      phase_reg <= ~phase_reg;
    end else begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign phase = phase_reg;

endmodule

// File: rtl/tile_palette.sv
// Tile value to RGB palette lookup with one-cycle latency, runtime writes,
// bulk restore to defaults and optional blinking highlight of one value.
module tile_palette
  import tile_palette_pkg::*;
#(
  parameter int VALUE_W      = 4,
  parameter int ENTRIES      = 16,
  parameter int COLOR_W      = 24,
  parameter int BLINK_PERIOD = 25_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               value_valid,
  input  logic [VALUE_W-1:0] value,
  input  logic               wr_en,
  input  logic [VALUE_W-1:0] wr_addr,
  input  logic [COLOR_W-1:0] wr_data,
  input  logic               restore,
  input  logic               hl_en,
  input  logic [VALUE_W-1:0] hl_value,
  output logic               pixel_valid,
  output logic [COLOR_W-1:0] pixel_color,
  output logic               blink_phase
);

  logic [COLOR_W-1:0] palette [ENTRIES];
  logic [COLOR_W-1:0] lookup_color;
  logic               pixel_valid_reg;
  logic [COLOR_W-1:0] pixel_color_reg;

  // One register per entry; addresses with no matching entry never write.
  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
      logic [COLOR_W-1:0] entry_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          entry_reg <= COLOR_W'(default_color(gi));
        end else if (restore) begin
          entry_reg <= COLOR_W'(default_color(gi));
        end else if (wr_en && (wr_addr == VALUE_W'(gi))) begin
          entry_reg <= wr_data;
        end
      end

      assign palette[gi] = entry_reg;
    end
  endgenerate

  // Read sees pre-write contents, giving read-before-write on collisions.
  always_comb begin
    lookup_color = COLOR_W'(DEFAULT_COLOR);
    for (int i = 0; i < ENTRIES; i++) begin
      if (value == VALUE_W'(i)) begin
        lookup_color = palette[i];
      end
    end
    if (blink_phase && (value == hl_value)) begin
      lookup_color = ~lookup_color;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_valid_reg <= 1'b0;
      pixel_color_reg <= '0;
    end else begin
      pixel_valid_reg <= value_valid;
      if (value_valid) begin
        pixel_color_reg <= lookup_color;
      end
    end
  end

  assign pixel_valid = pixel_valid_reg;
  assign pixel_color = pixel_color_reg;

  blink_timer #(
    .BLINK_PERIOD(BLINK_PERIOD)
  ) u_blink_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (hl_en),
    .phase(blink_phase)
  );

endmodule
